// File: rtl/sipo_pkg.sv
// Shared types and constants for the framed serial receiver.
package sipo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2,
        HOLD  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sipo_shift_en.sv
// Right-shifting serial-in/parallel-out register; new bits enter at the MSB.
module sipo_shift_en #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
        reg_d = reg_q;
        if (shift_en) begin
            reg_d = {sdi, reg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit, WIDTH data bits LSB-first, stop bit,
// with the assembled word presented on a valid/ready handshake.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdi,
    input  logic             sdi_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             shift_en_c;
    logic [WIDTH-1:0] shreg;

    sipo_shift_en #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en_c),
        .sdi      (sdi),
        .q        (shreg)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        shift_en_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (sdi_valid && (sdi == START_BIT)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (sdi_valid) begin
                    shift_en_c = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (sdi_valid) begin
                    if (sdi == STOP_BIT) begin
                        state_d     = HOLD;
                        out_data_d  = shreg;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // A start bit here is never captured, even on the transfer cycle.
                if (sdi_valid && (sdi == START_BIT)) begin
                    overrun_d = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: per-scenario tasks plus a
// scoreboard of expected words popped on every handshake transfer.
module tb_sipo_frame_ctrl;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         sdi;
    logic         sdi_valid;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int tests_run = 0;
    int failures  = 0;
    int vld_cycles = 0;
    int fe_cnt     = 0;
    int ov_cnt     = 0;
    int both_cnt   = 0;
    logic [W-1:0] exp_q[$];

    sipo_frame_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sdi       (sdi),
        .sdi_valid (sdi_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) vld_cycles++;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) both_cnt++;
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_extra: got word %h, expected none", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        failures++;
                        $display("FAIL scoreboard_word: got %h, expected %h", out_data, e);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One sdi_valid strobe, then `gap` strobe-free cycles with junk on sdi.
    task automatic strobe(input logic b, input int gap);
        sdi       = b;
        sdi_valid = 1'b1;
        @(posedge clk);
        #1;
        sdi_valid = 1'b0;
        sdi       = 1'($urandom);
        idle(gap);
    endtask

    task automatic send_word(input logic [W-1:0] data, input int gap);
        logic [W-1:0] d;
        d = data;
        strobe(1'b0, gap);
        for (int i = 0; i < int'(W); i++) begin
            strobe(d[i], gap);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({out_data, out_valid, busy, frame_err, overrun} !== '0) begin
            failures++;
            $display("FAIL reset_state: got data=%h v=%b busy=%b fe=%b ov=%b, expected all 0",
                     out_data, out_valid, busy, frame_err, overrun);
        end
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        strobe(1'b1, 0);
        tests_run++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_shift_busy: got %b, expected 1", busy);
        end
        #3 rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_shift_abort: got v=%b busy=%b, expected 0 0", out_valid, busy);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(4'b0110);
        send_word(4'b0110, 0);
        strobe(1'b1, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 4'b0110) begin
            failures++;
            $display("FAIL post_reset_frame: got v=%b data=%h, expected 1 6", out_valid, out_data);
        end
        idle(2);
    endtask

    task automatic test_nominal();
        out_ready  = 1'b1;
        vld_cycles = 0;
        exp_q.push_back(4'hD);
        send_word(4'hD, 0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL nominal_early_valid: got %b, expected 0", out_valid);
        end
        strobe(1'b1, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 4'hD) begin
            failures++;
            $display("FAIL nominal_latency: got v=%b data=%h, expected 1 d", out_valid, out_data);
        end
        idle(1);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL nominal_release: got v=%b busy=%b, expected 0 0", out_valid, busy);
        end
        idle(2);
        tests_run++;
        if (vld_cycles != 1) begin
            failures++;
            $display("FAIL nominal_valid_width: got %0d cycles, expected 1", vld_cycles);
        end
    endtask

    task automatic test_backpressure();
        out_ready  = 1'b0;
        vld_cycles = 0;
        exp_q.push_back(4'hD);
        send_word(4'hD, 0);
        strobe(1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 4'hD) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got v=%b data=%h, expected 1 d",
                         k, out_valid, out_data);
            end
            idle(1);
        end
        out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_last: got v=%b, expected 1", out_valid);
        end
        idle(1);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: got v=%b busy=%b, expected 0 0", out_valid, busy);
        end
        tests_run++;
        if (vld_cycles != 6) begin
            failures++;
            $display("FAIL backpressure_width: got %0d cycles, expected 6", vld_cycles);
        end
    endtask

    task automatic test_frame_err();
        out_ready  = 1'b1;
        fe_cnt     = 0;
        vld_cycles = 0;
        send_word(4'hF, 0);
        strobe(1'b0, 0);
        tests_run++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_pulse: got fe=%b v=%b busy=%b, expected 1 0 0",
                     frame_err, out_valid, busy);
        end
        idle(1);
        tests_run++;
        if (frame_err !== 1'b0 || fe_cnt != 1 || vld_cycles != 0) begin
            failures++;
            $display("FAIL frame_err_once: got fe=%b count=%0d vcyc=%0d, expected 0 1 0",
                     frame_err, fe_cnt, vld_cycles);
        end
        exp_q.push_back(4'h8);
        send_word(4'h8, 0);
        strobe(1'b1, 0);
        idle(2);
        tests_run++;
        if (out_data !== 4'h8) begin
            failures++;
            $display("FAIL frame_err_recover: got %h, expected 8", out_data);
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        ov_cnt    = 0;
        exp_q.push_back(4'h3);
        send_word(4'h3, 0);
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        tests_run++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out_data !== 4'h3) begin
            failures++;
            $display("FAIL overrun_pulse: got ov=%b v=%b data=%h, expected 1 1 3",
                     overrun, out_valid, out_data);
        end
        idle(1);
        tests_run++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_width: got %b, expected 0", overrun);
        end
        for (int i = 0; i < int'(W) + 1; i++) begin
            strobe(1'b1, 0);
        end
        tests_run++;
        if (ov_cnt != 1 || out_data !== 4'h3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold: got count=%0d data=%h busy=%b, expected 1 3 1",
                     ov_cnt, out_data, busy);
        end
        out_ready = 1'b1;
        idle(5);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_drop: got busy=%b v=%b, expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_gapped();
        out_ready  = 1'b1;
        vld_cycles = 0;
        strobe(1'b1, 2);
        strobe(1'b1, 2);
        strobe(1'b1, 2);
        tests_run++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL gapped_idle_line: got busy=%b, expected 0", busy);
        end
        exp_q.push_back(4'hD);
        strobe(1'b0, 2);
        strobe(1'b1, 2);
        strobe(1'b0, 2);
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL gapped_mid: got busy=%b v=%b, expected 1 0", busy, out_valid);
        end
        strobe(1'b1, 2);
        strobe(1'b1, 2);
        strobe(1'b1, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 4'hD) begin
            failures++;
            $display("FAIL gapped_word: got v=%b data=%h, expected 1 d", out_valid, out_data);
        end
        idle(3);
        tests_run++;
        if (vld_cycles != 1) begin
            failures++;
            $display("FAIL gapped_width: got %0d cycles, expected 1", vld_cycles);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        exp_q.push_back(4'hA);
        exp_q.push_back(4'h5);
        send_word(4'hA, 0);
        strobe(1'b1, 1);
        send_word(4'h5, 0);
        strobe(1'b1, 0);
        idle(2);
        tests_run++;
        if (out_data !== 4'h5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL back_to_back: got data=%h pending=%0d, expected 5 0",
                     out_data, exp_q.size());
        end
    endtask

    task automatic test_reset_in_hold();
        out_ready = 1'b0;
        send_word(4'h9, 0);
        strobe(1'b1, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 4'h9) begin
            failures++;
            $display("FAIL hold_before_reset: got v=%b data=%h, expected 1 9", out_valid, out_data);
        end
        #3 rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 4'h0) begin
            failures++;
            $display("FAIL hold_reset: got v=%b busy=%b data=%h, expected 0 0 0",
                     out_valid, busy, out_data);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        tests_run++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_reset_after: got v=%b, expected 0", out_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        sdi       = 1'b1;
        sdi_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        idle(2);
        test_reset_mid_shift();
        test_nominal();
        test_backpressure();
        test_frame_err();
        test_overrun();
        test_gapped();
        test_back_to_back();
        test_reset_in_hold();
        tests_run++;
        if (exp_q.size() != 0 || both_cnt != 0) begin
            failures++;
            $display("FAIL final_state: pending=%0d fe_and_ov=%0d, expected 0 0",
                     exp_q.size(), both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
